uart_tx_param: RTL and testbench

Parametrised successor to the team's fixed 8N1 UART transmitter. Serialises one DATA_BITS-wide word per frame with a runtime-selectable baud rate, a dedicated parity bit (data bits are never overwritten), 1 or 2 stop bits, and a valid/ready handshake toward the upstream producer. Sits between the core-side byte source and the TX pin.

---
 rtl/uart_tx_param.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS data bits, optional odd/even parity, 1 or 2 stop bits,
// runtime baud select and a valid/ready handshake. Define UART_TX_BREAK_EN to add the sendBreak input.
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int CLKS_1200 = 41667,
  parameter int CLKS_2400 = 20833,
  parameter int CLKS_4800 = 10417,
  parameter int CLKS_9600 = 5208,
  parameter int CNT_W     = 16
) (
  input  logic                 clkTx,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] dataInput,
  input  logic                 dataValid,
  output logic                 dataReady,
  input  logic [1:0]           baudRate,
  input  logic [1:0]           parity,
  input  logic                 stopBits,
`ifdef UART_TX_BREAK_EN
  input  logic                 sendBreak,
`endif
  output logic                 serialOut,
  output logic                 busy,
  output logic                 txDone
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   shiftReg;
  logic [CNT_W-1:0]       clkCount;
  logic [CNT_W-1:0]       lastCnt;
  logic [IDX_W-1:0]       bitIdx;
  logic                   parEnSh;
  logic                   parBitSh;
  logic                   stop2Sh;
  logic                   stopSecond;
  logic                   brkReq;
  logic                   bitDone;
  logic [CNT_W-1:0]       cntNext;
  logic                   accept;

  function automatic logic [CNT_W-1:0] bit_last(input logic [1:0] sel);
    case (sel)
      2'b00:   return CNT_W'(CLKS_1200 - 1);
      2'b01:   return CNT_W'(CLKS_2400 - 1);
      2'b10:   return CNT_W'(CLKS_4800 - 1);
      default: return CNT_W'(CLKS_9600 - 1);
    endcase
  endfunction

  // Odd mode makes the total ones count odd, even mode makes it even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] mode);
    return (mode == 2'b01) ? ~(^d) : (^d);
  endfunction

`ifdef UART_TX_BREAK_EN
  assign brkReq = sendBreak;
`else
  assign brkReq = 1'b0;
`endif

  assign bitDone = (clkCount == lastCnt);
  assign cntNext = clkCount + 1'b1;
  // Break gates acceptance directly so a just-raised break never starts a frame.
  assign accept  = dataValid && dataReady && !brkReq;

  always_ff @(posedge clkTx) begin
    if (!reset) begin
      state      <= IDLE;
      serialOut  <= 1'b1;
      dataReady  <= 1'b1;
      busy       <= 1'b0;
      txDone     <= 1'b0;
      clkCount   <= '0;
      lastCnt    <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      parEnSh    <= 1'b0;
      parBitSh   <= 1'b0;
      stop2Sh    <= 1'b0;
      stopSecond <= 1'b0;
    end else begin
      txDone <= 1'b0;
      case (state)
        IDLE: begin
          clkCount   <= '0;
          bitIdx     <= '0;
          stopSecond <= 1'b0;
          if (accept) begin
            shiftReg  <= dataInput;
            lastCnt   <= bit_last(baudRate);
            parEnSh   <= (parity == 2'b01) || (parity == 2'b10);
            parBitSh  <= parity_bit(dataInput, parity);
            stop2Sh   <= stopBits;
            state     <= START;
            serialOut <= 1'b0;
            dataReady <= 1'b0;
            busy      <= 1'b1;
          end else begin
            serialOut <= !brkReq;
            dataReady <= !brkReq;
          end
        end
        START: begin
          if (bitDone) begin
            clkCount  <= '0;
            state     <= DATA;
            serialOut <= shiftReg[0];
          end else begin
            clkCount <= cntNext;
          end
        end
        DATA: begin
          if (bitDone) begin
            clkCount <= '0;
            if (bitIdx == LAST_IDX) begin
              if (parEnSh) begin
                state     <= PARITY;
                serialOut <= parBitSh;
              end else begin
                state     <= STOP;
                serialOut <= 1'b1;
                txDone    <= !stop2Sh && (lastCnt == '0);
              end
            end else begin
              bitIdx    <= bitIdx + 1'b1;
              shiftReg  <= shiftReg >> 1;
              serialOut <= shiftReg[1];
            end
          end else begin
            clkCount <= cntNext;
          end
        end
        PARITY: begin
          if (bitDone) begin
            clkCount  <= '0;
            state     <= STOP;
            serialOut <= 1'b1;
            txDone    <= !stop2Sh && (lastCnt == '0);
          end else begin
            clkCount <= cntNext;
          end
        end
        STOP: begin
          // txDone is registered, so it is raised on the edge entering the final stop cycle.
          if (bitDone) begin
            clkCount <= '0;
            if (stop2Sh && !stopSecond) begin
              stopSecond <= 1'b1;
              txDone     <= (lastCnt == '0);
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              serialOut <= !brkReq;
              dataReady <= !brkReq;
            end
          end else begin
            clkCount <= cntNext;
            txDone   <= (!stop2Sh || stopSecond) && (cntNext == lastCnt);
          end
        end
        default: begin
          state     <= IDLE;
          serialOut <= 1'b1;
          dataReady <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table of frames at several baud selects, plus back-to-back,
// mid-frame reset and (when UART_TX_BREAK_EN is defined) break sequences.
module tb_uart_tx_param;

  logic       clkTx = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dataInput = 8'h00;
  logic       dataValid = 1'b0;
  logic       dataReady;
  logic [1:0] baudRate = 2'b11;
  logic [1:0] parity = 2'b00;
  logic       stopBits = 1'b0;
  logic       serialOut;
  logic       busy;
  logic       txDone;
`ifdef UART_TX_BREAK_EN
  logic       sendBreak = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clkTx = ~clkTx;

  uart_tx_param #(
    .DATA_BITS(8),
    .CLKS_1200(7),
    .CLKS_2400(6),
    .CLKS_4800(5),
    .CLKS_9600(4),
    .CNT_W(16)
  ) dut (
    .clkTx(clkTx),
    .reset(reset),
    .dataInput(dataInput),
    .dataValid(dataValid),
    .dataReady(dataReady),
    .baudRate(baudRate),
    .parity(parity),
    .stopBits(stopBits),
`ifdef UART_TX_BREAK_EN
    .sendBreak(sendBreak),
`endif
    .serialOut(serialOut),
    .busy(busy),
    .txDone(txDone)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  baud;
    logic [1:0]  par;
    logic        stop2;
    logic [11:0] bits;
    int          nbits;
    int          n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the handshake set up; checks every cycle of the frame and the cycle after.
  task automatic check_frame(input logic [11:0] bits, input int nbits, input int n, input logic hold,
                             input logic [7:0] newData, input logic brk, input string tag);
    int len;
    len = nbits * n;
    for (int c = 1; c <= len; c++) begin
      @(negedge clkTx);
      if (c == 1) begin
        dataInput = newData;
        if (!hold) dataValid = 1'b0;
`ifdef UART_TX_BREAK_EN
        sendBreak = brk;
`endif
      end
      chk($sformatf("%s.serialOut@%0d", tag, c), 32'(serialOut), 32'(bits[(c-1)/n]));
      chk($sformatf("%s.busy@%0d", tag, c), 32'(busy), 32'(1'b1));
      chk($sformatf("%s.dataReady@%0d", tag, c), 32'(dataReady), 32'(1'b0));
      chk($sformatf("%s.txDone@%0d", tag, c), 32'(txDone), 32'(c == len));
    end
    @(negedge clkTx);
    chk($sformatf("%s.idle.serialOut", tag), 32'(serialOut), 32'(!brk));
    chk($sformatf("%s.idle.dataReady", tag), 32'(dataReady), 32'(!brk));
    chk($sformatf("%s.idle.busy", tag), 32'(busy), 32'(1'b0));
    chk($sformatf("%s.idle.txDone", tag), 32'(txDone), 32'(1'b0));
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'b11, 2'b00, 1'b0, 12'h34A, 10, 4};
    vecs[1] = '{8'h07, 2'b11, 2'b01, 1'b0, 12'h40E, 11, 4};
    vecs[2] = '{8'h07, 2'b11, 2'b10, 1'b0, 12'h60E, 11, 4};
    vecs[3] = '{8'hFF, 2'b11, 2'b01, 1'b1, 12'hFFE, 12, 4};
    vecs[4] = '{8'h00, 2'b10, 2'b10, 1'b0, 12'h400, 11, 5};
    vecs[5] = '{8'h3C, 2'b01, 2'b00, 1'b1, 12'h678, 11, 6};
    vecs[6] = '{8'h55, 2'b00, 2'b11, 1'b0, 12'h2AA, 10, 7};
    vecs[7] = '{8'hC3, 2'b10, 2'b01, 1'b1, 12'hF86, 12, 5};

    reset = 1'b0;
    repeat (3) @(posedge clkTx);
    @(negedge clkTx);
    chk("reset.serialOut", 32'(serialOut), 32'(1'b1));
    chk("reset.dataReady", 32'(dataReady), 32'(1'b1));
    chk("reset.busy", 32'(busy), 32'(1'b0));
    chk("reset.txDone", 32'(txDone), 32'(1'b0));
    reset = 1'b1;
    @(negedge clkTx);

    for (int i = 0; i < 8; i++) begin
      dataInput = vecs[i].data;
      baudRate  = vecs[i].baud;
      parity    = vecs[i].par;
      stopBits  = vecs[i].stop2;
      dataValid = 1'b1;
      chk($sformatf("vec%0d.readyBefore", i), 32'(dataReady), 32'(1'b1));
      check_frame(vecs[i].bits, vecs[i].nbits, vecs[i].n, 1'b0, ~vecs[i].data, 1'b0,
                  $sformatf("vec%0d", i));
    end

    // Back-to-back with dataValid held; dataInput changes during frame one.
    dataInput = 8'h01;
    baudRate  = 2'b11;
    parity    = 2'b00;
    stopBits  = 1'b0;
    dataValid = 1'b1;
    check_frame(12'h202, 10, 4, 1'b1, 8'h80, 1'b0, "b2b1");
    check_frame(12'h300, 10, 4, 1'b0, 8'h80, 1'b0, "b2b2");

    // Reset asserted during data bit 3 (cycles 17..20 of the frame).
    dataInput = 8'hA5;
    dataValid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clkTx);
      if (c == 1) dataValid = 1'b0;
      if (c == 17) chk("rst.bit3", 32'(serialOut), 32'(1'b0));
      if (c == 18) reset = 1'b0;
    end
    @(negedge clkTx);
    chk("rst.serialOut", 32'(serialOut), 32'(1'b1));
    chk("rst.busy", 32'(busy), 32'(1'b0));
    chk("rst.dataReady", 32'(dataReady), 32'(1'b1));
    chk("rst.txDone", 32'(txDone), 32'(1'b0));
    reset = 1'b1;
    dataInput = 8'h3C;
    baudRate  = 2'b01;
    stopBits  = 1'b1;
    dataValid = 1'b1;
    check_frame(12'h678, 11, 6, 1'b0, 8'h00, 1'b0, "postRst");

`ifdef UART_TX_BREAK_EN
    sendBreak = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clkTx);
      chk($sformatf("brk.serialOut@%0d", c), 32'(serialOut), 32'(1'b0));
      chk($sformatf("brk.dataReady@%0d", c), 32'(dataReady), 32'(1'b0));
      chk($sformatf("brk.busy@%0d", c), 32'(busy), 32'(1'b0));
    end
    sendBreak = 1'b0;
    @(negedge clkTx);
    chk("brk.release.serialOut", 32'(serialOut), 32'(1'b1));
    chk("brk.release.dataReady", 32'(dataReady), 32'(1'b1));
    dataInput = 8'hA5;
    baudRate  = 2'b11;
    parity    = 2'b00;
    stopBits  = 1'b0;
    dataValid = 1'b1;
    check_frame(12'h34A, 10, 4, 1'b0, 8'h00, 1'b1, "brkMid");
    sendBreak = 1'b0;
    @(negedge clkTx);
    chk("brkMid.release.serialOut", 32'(serialOut), 32'(1'b1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
